// File: rtl/rv_instr_encoder_loader_pkg.sv
// ============================================================================
// Module      : rv_encode_pkg
// Description : Format codes, RV32I opcodes and loader FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_encode_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rv_instr_encoder_loader_if.sv
// ============================================================================
// Module      : rv_instr_encoder_loader_if
// Description : Field-bundle stream in, instruction-memory write bus out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv_instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/rv_instr_encoder_loader_packer.sv
// ============================================================================
// Module      : rv_field_packer
// Description : Combinational RV32I field-to-word encoder with legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_field_packer
  import rv_encode_pkg::*;
(
  input  wire logic [2:0]  fmt_i,
  input  wire logic [6:0]  op_i,
  input  wire logic [4:0]  rd_i,
  input  wire logic [4:0]  rs1_i,
  input  wire logic [4:0]  rs2_i,
  input  wire logic [2:0]  funct3_i,
  input  wire logic [6:0]  funct7_i,
  input  wire logic [31:0] imm_i,
  output logic      [31:0] word_o,
  output logic             legal_o
);

  always_comb begin
    word_o  = 32'h0;
    legal_o = 1'b1;
    case (fmt_i)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], op_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, op_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
      default: legal_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_instr_encoder_loader.sv
// ============================================================================
// Module      : rv_instr_encoder_loader
// Description : Streams encoded RV32I words into instruction memory, holding
//               the core in reset until the program is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_instr_encoder_loader
  import rv_encode_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  start,
  rv_instr_encoder_loader_if.slave   bus,
  output logic      [ADDR_WIDTH:0]   count,
  output logic                       busy,
  output logic                       done,
  output logic                       cpu_rst_n,
  output logic                       err_fmt,
  output logic                       err_full
);

  localparam logic [ADDR_WIDTH:0] c_last_idx = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] c_one      = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cpu_rst_n_q;
  logic                  err_fmt_q;
  logic                  err_full_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  mem_we_q;
  logic [31:0]           mem_addr_q;
  logic [31:0]           mem_wdata_q;

  logic [31:0]           word_d;
  logic                  legal_d;
  logic [31:0]           addr_d;
  logic                  accept_d;
  logic                  full_d;
  logic                  finish_d;

  rv_field_packer u_packer (
    .fmt_i    (bus.in_fmt),
    .op_i     (bus.in_op),
    .rd_i     (bus.in_rd),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .funct3_i (bus.in_funct3),
    .funct7_i (bus.in_funct7),
    .imm_i    (bus.in_imm),
    .word_o   (word_d),
    .legal_o  (legal_d)
  );

  assign addr_d   = BASE_ADDR + 32'({count_q, 2'b00});
  assign accept_d = bus.in_valid && ready_q;
  // Capacity only ends the session when the final slot is filled by a non-last word.
  assign full_d   = legal_d && (count_q == c_last_idx) && !bus.in_last;
  assign finish_d = bus.in_last || full_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      err_fmt_q   <= 1'b0;
      err_full_q  <= 1'b0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Release lags done by one cycle so the core never sees a half-loaded image.
          if (state_q == ST_DONE) cpu_rst_n_q <= 1'b1;
          if (start) begin
            state_q     <= ST_LOAD;
            ready_q     <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            err_fmt_q   <= 1'b0;
            err_full_q  <= 1'b0;
            count_q     <= '0;
          end
        end
        ST_LOAD: begin
          if (accept_d) begin
            if (legal_d) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_d;
              mem_wdata_q <= word_d;
              count_q     <= count_q + c_one;
            end else begin
              err_fmt_q <= 1'b1;
            end
            if (full_d) err_full_q <= 1'b1;
            if (finish_d) begin
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign count         = count_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign err_fmt       = err_fmt_q;
  assign err_full      = err_full_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_instr_encoder_loader.sv
// ============================================================================
// Module      : tb_rv_instr_encoder_loader
// Description : Directed-vector bench for the RV32I encoder/loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_instr_encoder_loader;
  import rv_encode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a;
  logic       start_b;
  logic [8:0] count_a;
  logic [2:0] count_b;
  logic       busy_a, done_a, cpu_rst_n_a, err_fmt_a, err_full_a;
  logic       busy_b, done_b, cpu_rst_n_b, err_fmt_b, err_full_b;
  int         n_checks = 0;
  int         n_errors = 0;

  rv_instr_encoder_loader_if bus_a ();
  rv_instr_encoder_loader_if bus_b ();

  rv_instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0)) u_dut_a (
    .clk(clk), .rst(rst_n), .start(start_a), .bus(bus_a),
    .count(count_a), .busy(busy_a), .done(done_a), .cpu_rst_n(cpu_rst_n_a),
    .err_fmt(err_fmt_a), .err_full(err_full_a)
  );

  rv_instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(32'h0)) u_dut_b (
    .clk(clk), .rst(rst_n), .start(start_b), .bus(bus_b),
    .count(count_b), .busy(busy_b), .done(done_b), .cpu_rst_n(cpu_rst_n_b),
    .err_fmt(err_fmt_b), .err_full(err_full_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm, input logic last);
    bus_a.in_valid  = 1'b1;
    bus_a.in_fmt    = fmt;
    bus_a.in_op     = op;
    bus_a.in_rd     = rd;
    bus_a.in_rs1    = rs1;
    bus_a.in_rs2    = rs2;
    bus_a.in_funct3 = f3;
    bus_a.in_funct7 = f7;
    bus_a.in_imm    = imm;
    bus_a.in_last   = last;
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, ".we"},    32'(bus_a.mem_we), 32'd1);
    check({tag, ".addr"},  bus_a.mem_addr,    addr);
    check({tag, ".wdata"}, bus_a.mem_wdata,   data);
  endtask

  task automatic chk_reset_a(input string tag);
    check({tag, ".ready"},    32'(bus_a.in_ready), 32'd0);
    check({tag, ".we"},       32'(bus_a.mem_we),   32'd0);
    check({tag, ".addr"},     bus_a.mem_addr,      32'd0);
    check({tag, ".wdata"},    bus_a.mem_wdata,     32'd0);
    check({tag, ".count"},    32'(count_a),        32'd0);
    check({tag, ".busy"},     32'(busy_a),         32'd0);
    check({tag, ".done"},     32'(done_a),         32'd0);
    check({tag, ".cpu_rst"},  32'(cpu_rst_n_a),    32'd0);
    check({tag, ".err_fmt"},  32'(err_fmt_a),      32'd0);
    check({tag, ".err_full"}, 32'(err_full_a),     32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    drive_a(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
    bus_a.in_valid  = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_fmt    = FMT_I;
    bus_b.in_op     = OP_ITYPE;
    bus_b.in_rd     = 5'd0;
    bus_b.in_rs1    = 5'd0;
    bus_b.in_rs2    = 5'd0;
    bus_b.in_funct3 = 3'd0;
    bus_b.in_funct7 = 7'd0;
    bus_b.in_imm    = 32'd1;
    bus_b.in_last   = 1'b0;

    #12;
    chk_reset_a("rst");
    step();
    rst_n = 1'b1;
    step();
    check("idle.ready", 32'(bus_a.in_ready), 32'd0);

    // addi x1,x0,5 then add x3,x1,x2 (last)
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("s1.busy",  32'(busy_a),         32'd1);
    check("s1.ready", 32'(bus_a.in_ready), 32'd1);
    check("s1.cpu",   32'(cpu_rst_n_a),    32'd0);
    drive_a(FMT_I, OP_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    step();
    chk_wr("s1w0", 32'h0, 32'h00500093);
    check("s1w0.count", 32'(count_a), 32'd1);
    check("s1w0.done",  32'(done_a),  32'd0);
    drive_a(FMT_R, OP_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
    step();
    bus_a.in_valid = 1'b0;
    chk_wr("s1w1", 32'h4, 32'h002081B3);
    check("s1w1.count", 32'(count_a),        32'd2);
    check("s1w1.done",  32'(done_a),         32'd1);
    check("s1w1.ready", 32'(bus_a.in_ready), 32'd0);
    check("s1w1.cpu",   32'(cpu_rst_n_a),    32'd0);
    step();
    check("s1.rel.cpu", 32'(cpu_rst_n_a),  32'd1);
    check("s1.rel.we",  32'(bus_a.mem_we), 32'd0);
    check("s1.rel.done", 32'(done_a),      32'd1);

    // Re-arm from DONE, four back-to-back formats
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("s2.cpu",   32'(cpu_rst_n_a), 32'd0);
    check("s2.count", 32'(count_a),     32'd0);
    check("s2.busy",  32'(busy_a),      32'd1);
    drive_a(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
    step();
    chk_wr("s2w0", 32'h0, 32'h0020A423);
    drive_a(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
    step();
    chk_wr("s2w1", 32'h4, 32'hFE208EE3);
    drive_a(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
    step();
    chk_wr("s2w2", 32'h8, 32'h123452B7);
    drive_a(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1);
    step();
    bus_a.in_valid = 1'b0;
    chk_wr("s2w3", 32'hC, 32'h008000EF);
    check("s2.count",    32'(count_a),    32'd4);
    check("s2.done",     32'(done_a),     32'd1);
    check("s2.err_full", 32'(err_full_a), 32'd0);
    step();
    check("s2.idle.we", 32'(bus_a.mem_we), 32'd0);

    // Illegal format dropped between two legal words
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    drive_a(FMT_I, OP_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    step();
    chk_wr("s3w0", 32'h0, 32'h00500093);
    drive_a(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_FFFF, 1'b0);
    step();
    check("s3bad.we",    32'(bus_a.mem_we), 32'd0);
    check("s3bad.err",   32'(err_fmt_a),    32'd1);
    check("s3bad.count", 32'(count_a),      32'd1);
    drive_a(FMT_R, OP_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
    step();
    bus_a.in_valid = 1'b0;
    chk_wr("s3w1", 32'h4, 32'h002081B3);
    check("s3.count", 32'(count_a),   32'd2);
    check("s3.err",   32'(err_fmt_a), 32'd1);

    // Reset mid-LOAD after two writes, then restart
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("s4.err_clr", 32'(err_fmt_a), 32'd0);
    drive_a(FMT_I, OP_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    step();
    drive_a(FMT_R, OP_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
    step();
    chk_wr("s4w1", 32'h4, 32'h002081B3);
    bus_a.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_a("s4rst");
    step();
    rst_n = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    drive_a(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
    step();
    bus_a.in_valid = 1'b0;
    chk_wr("s4w0", 32'h0, 32'h123452B7);
    check("s4.count", 32'(count_a), 32'd1);

    // Small memory: six bundles without last fill four slots
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    bus_b.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_b.in_rd = 5'(i);
      step();
      if (i < 4) begin
        check($sformatf("full%0d.we", i),    32'(bus_b.mem_we), 32'd1);
        check($sformatf("full%0d.addr", i),  bus_b.mem_addr,    32'(4 * i));
        check($sformatf("full%0d.wdata", i), bus_b.mem_wdata,
              32'h0010_0013 | (32'(i) << 7));
      end else begin
        check($sformatf("full%0d.we", i), 32'(bus_b.mem_we), 32'd0);
      end
      if (i == 2) check("full2.err", 32'(err_full_b), 32'd0);
      if (i >= 3) begin
        check($sformatf("full%0d.err", i),   32'(err_full_b),     32'd1);
        check($sformatf("full%0d.ready", i), 32'(bus_b.in_ready), 32'd0);
        check($sformatf("full%0d.done", i),  32'(done_b),         32'd1);
        check($sformatf("full%0d.count", i), 32'(count_b),        32'd4);
      end
    end
    bus_b.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
